// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline register/hazard info in, stall/flush/forward controls out.
interface hazard_if;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic        load_e;
    logic        pc_src_e;
    logic [4:0]  rd_m;
    logic        reg_write_m;
    logic        mem_req_m;
    logic [4:0]  rd_w;
    logic        reg_write_w;
    logic [1:0]  forward_a_e;
    logic [1:0]  forward_b_e;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        flush_w;
    logic        mem_busy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, mem_req_m, rd_w, reg_write_w,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, mem_req_m, rd_w, reg_write_w,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for a 5-stage RV32I pipeline: forwarding, load-use stall,
// branch flush, multi-cycle data-memory wait and stall/flush counters.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_RUN  | pipeline flowing; a memory access in M starts the wait
//   ST_WAIT | F..M frozen while wait_cnt counts the remaining memory cycles
module hazard_unit #(
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam bit       HAS_WAIT = (MEM_LATENCY != 0);
    localparam logic [2:0] LAT_M1 = HAS_WAIT ? 3'(MEM_LATENCY - 1) : 3'd0;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_nxt;
    logic        mem_stall;
    logic        lw_hazard;
    logic        branch_flush;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_d;
    logic        flush_e;
    logic        flush_w;
    logic        busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RUN;
            wait_cnt    <= 3'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (stall_f) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    // mem_req_m is not looked at in ST_WAIT: the same access is still in M.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        mem_stall = 1'b0;
        case (state)
            ST_RUN: begin
                if (hz.mem_req_m && HAS_WAIT) begin
                    mem_stall = 1'b1;
                    state_nxt = ST_WAIT;
                    wait_nxt  = LAT_M1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt != 3'd0) begin
                    mem_stall = 1'b1;
                    wait_nxt  = wait_cnt - 3'd1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = 3'd0;
            end
        endcase
    end

    always_comb begin
        lw_hazard = hz.load_e && (hz.rd_e != 5'd0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
        branch_flush = rst && !mem_stall && hz.pc_src_e;
    end

    always_comb begin
        fwd_a = 2'b00;
        if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs1_e)) begin
            fwd_a = 2'b10;
        end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_e)) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs2_e)) begin
            fwd_b = 2'b10;
        end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_e)) begin
            fwd_b = 2'b01;
        end
        if (!rst) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // Priority: reset, memory wait, taken branch, load-use.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        busy    = (state == ST_WAIT);
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            busy    = 1'b0;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.forward_a_e = fwd_a;
    assign hz.forward_b_e = fwd_b;
    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.stall_e     = stall_e;
    assign hz.stall_m     = stall_m;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.flush_w     = flush_w;
    assign hz.mem_busy    = busy;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (MEM_LATENCY 3, 0, 5) share one stimulus set.
module tb_hazard_unit;

    logic clk;
    logic rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, pc_src_e, reg_write_m, mem_req_m, reg_write_w;

    int total;
    int bad;

    hazard_if hif3 ();
    hazard_if hif0 ();
    hazard_if hif5 ();

    assign hif3.rs1_d = rs1_d;  assign hif0.rs1_d = rs1_d;  assign hif5.rs1_d = rs1_d;
    assign hif3.rs2_d = rs2_d;  assign hif0.rs2_d = rs2_d;  assign hif5.rs2_d = rs2_d;
    assign hif3.rs1_e = rs1_e;  assign hif0.rs1_e = rs1_e;  assign hif5.rs1_e = rs1_e;
    assign hif3.rs2_e = rs2_e;  assign hif0.rs2_e = rs2_e;  assign hif5.rs2_e = rs2_e;
    assign hif3.rd_e  = rd_e;   assign hif0.rd_e  = rd_e;   assign hif5.rd_e  = rd_e;
    assign hif3.load_e = load_e;       assign hif0.load_e = load_e;       assign hif5.load_e = load_e;
    assign hif3.pc_src_e = pc_src_e;   assign hif0.pc_src_e = pc_src_e;   assign hif5.pc_src_e = pc_src_e;
    assign hif3.rd_m = rd_m;    assign hif0.rd_m = rd_m;    assign hif5.rd_m = rd_m;
    assign hif3.reg_write_m = reg_write_m; assign hif0.reg_write_m = reg_write_m; assign hif5.reg_write_m = reg_write_m;
    assign hif3.mem_req_m = mem_req_m;     assign hif0.mem_req_m = mem_req_m;     assign hif5.mem_req_m = mem_req_m;
    assign hif3.rd_w = rd_w;    assign hif0.rd_w = rd_w;    assign hif5.rd_w = rd_w;
    assign hif3.reg_write_w = reg_write_w; assign hif0.reg_write_w = reg_write_w; assign hif5.reg_write_w = reg_write_w;

    hazard_unit #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .hz(hif3.slave));
    hazard_unit #(.MEM_LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .hz(hif0.slave));
    hazard_unit #(.MEM_LATENCY(5)) u_dut5 (.clk(clk), .rst(rst), .hz(hif5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1..2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0;
        load_e = 1'b0; pc_src_e = 1'b0; reg_write_m = 1'b0; mem_req_m = 1'b0; reg_write_w = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst = 1'b0;
        // Forwarding match present during reset must still read 00.
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
        step();
        step();
        #1;
        chk("rst_flush_d", 32'(hif3.flush_d), 32'd1);
        chk("rst_flush_e", 32'(hif3.flush_e), 32'd1);
        chk("rst_flush_w", 32'(hif3.flush_w), 32'd1);
        chk("rst_stall_f", 32'(hif3.stall_f), 32'd0);
        chk("rst_fwd_a",   32'(hif3.forward_a_e), 32'd0);
        chk("rst_busy",    32'(hif3.mem_busy), 32'd0);
        chk("rst_scnt",    hif3.stall_cnt, 32'd0);
        chk("rst_fcnt",    hif3.flush_cnt, 32'd0);
        rst = 1'b1;
        clear_inputs();
        step();
        #1;
        chk("idle_flush_d", 32'(hif3.flush_d), 32'd0);
        chk("idle_flush_w", 32'(hif3.flush_w), 32'd0);

        // Forwarding: M over W, then W, then none.
        rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
        rs1_e = 5'd5; rs2_e = 5'd9;
        #1;
        chk("fwd_a_m",  32'(hif3.forward_a_e), 32'd2);
        chk("fwd_b_0",  32'(hif3.forward_b_e), 32'd0);
        reg_write_m = 1'b0;
        #1;
        chk("fwd_a_w",  32'(hif3.forward_a_e), 32'd1);
        rd_w = 5'd0;
        #1;
        chk("fwd_a_none", 32'(hif3.forward_a_e), 32'd0);
        rd_m = 5'd9; reg_write_m = 1'b1; rd_w = 5'd9; reg_write_w = 1'b1;
        #1;
        chk("fwd_b_m",  32'(hif3.forward_b_e), 32'd2);
        rd_m = 5'd0; rs2_e = 5'd0; rd_w = 5'd0;
        #1;
        chk("fwd_b_x0", 32'(hif3.forward_b_e), 32'd0);
        clear_inputs();

        // Load-use on rs2_d.
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        chk("lu_stall_f", 32'(hif3.stall_f), 32'd1);
        chk("lu_stall_d", 32'(hif3.stall_d), 32'd1);
        chk("lu_flush_e", 32'(hif3.flush_e), 32'd1);
        chk("lu_stall_e", 32'(hif3.stall_e), 32'd0);
        chk("lu_flush_d", 32'(hif3.flush_d), 32'd0);
        step();
        load_e = 1'b0;
        #1;
        chk("lu_scnt",   hif3.stall_cnt, 32'd1);
        chk("lu_after",  32'(hif3.stall_f), 32'd0);
        load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
        #1;
        chk("lu_x0",     32'(hif3.stall_f), 32'd0);
        clear_inputs();

        // Branch wins over load-use.
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
        #1;
        chk("br_flush_d", 32'(hif3.flush_d), 32'd1);
        chk("br_flush_e", 32'(hif3.flush_e), 32'd1);
        chk("br_stall_f", 32'(hif3.stall_f), 32'd0);
        step();
        clear_inputs();
        #1;
        chk("br_fcnt", hif3.flush_cnt, 32'd1);
        chk("br_scnt", hif3.stall_cnt, 32'd1);

        // Stall counter wrap.
        load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        force u_dut3.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut3.stall_cnt_q;
        #1;
        chk("wrap_pre", hif3.stall_cnt, 32'hFFFF_FFFF);
        step();
        clear_inputs();
        #1;
        chk("wrap_cnt", hif3.stall_cnt, 32'd0);

        // Memory wait, latency 3 (and 0), with a taken branch held throughout.
        mem_req_m = 1'b1; pc_src_e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw_stall_f%0d", i), 32'(hif3.stall_f), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("mw_stall_m%0d", i), 32'(hif3.stall_m), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("mw_flush_w%0d", i), 32'(hif3.flush_w), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("mw_flush_d%0d", i), 32'(hif3.flush_d), (i < 3) ? 32'd0 : 32'd1);
            chk($sformatf("mw_busy%0d", i),    32'(hif3.mem_busy), (i >= 1) ? 32'd1 : 32'd0);
            chk($sformatf("l0_stall_f%0d", i), 32'(hif0.stall_f), 32'd0);
            chk($sformatf("l0_busy%0d", i),    32'(hif0.mem_busy), 32'd0);
            step();
        end
        clear_inputs();
        #1;
        chk("mw_run",  32'(hif3.mem_busy), 32'd0);
        chk("mw_scnt", hif3.stall_cnt, 32'd3);
        chk("mw_fcnt", hif3.flush_cnt, 32'd2);

        // Reset abandons a latency-5 access at wait_cnt=2.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        mem_req_m = 1'b1;
        step();
        step();
        step();
        #1;
        chk("r5_busy", 32'(hif5.mem_busy), 32'd1);
        chk("r5_stall", 32'(hif5.stall_f), 32'd1);
        rst = 1'b0;
        #1;
        chk("r5_flush_d", 32'(hif5.flush_d), 32'd1);
        chk("r5_flush_e", 32'(hif5.flush_e), 32'd1);
        chk("r5_flush_w", 32'(hif5.flush_w), 32'd1);
        chk("r5_stall_f", 32'(hif5.stall_f), 32'd0);
        chk("r5_busy_rst", 32'(hif5.mem_busy), 32'd0);
        step();
        rst = 1'b1;
        mem_req_m = 1'b0;
        #1;
        chk("r5_run",  32'(hif5.mem_busy), 32'd0);
        chk("r5_nost", 32'(hif5.stall_f), 32'd0);
        chk("r5_scnt", hif5.stall_cnt, 32'd0);
        chk("r5_fcnt", hif5.flush_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
